// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and its RAM array.
package dmem_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Allowed range for the access latency, in stall cycles.
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 7;

  // Wide enough to hold LATENCY_MAX-1 in the countdown counter.
  localparam int CNT_W = 3;

  // Word-index width for a RAM of the given depth (ceil(log2(depth))).
  function automatic int clog2(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed synchronous RAM with one write port and one registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;

  // Read register keeps its last value until a new read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[idx];
    end
  end

  // Storage array is never reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read-data register clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: captures a datapath memory request, stalls for a fixed
// latency, then performs the access on the internal RAM.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err
);

  localparam int             IDX_W    = clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             is_write_q, is_write_d;
  logic             err_q, err_d;

  logic             request;
  logic             legal;
  logic             fire;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic             acc_write;

  // Classify the request currently presented by the datapath.
  always_comb begin
    request = MemRead | MemWrite;
    legal   = (MemRead ^ MemWrite) &&
              (addr[1:0] == 2'b00) &&
              ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
  end

  // Next-state logic; the RAM access fires on the edge that enters DONE, using
  // the live inputs when the latency is one cycle and the captured ones otherwise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    err_d      = 1'b0;
    fire       = 1'b0;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    acc_write  = is_write_q;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          idx_d      = addr[IDX_W+1:2];
          wdata_d    = write_data;
          is_write_d = MemWrite;
          cnt_d      = CNT_LOAD;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d   = DONE;
            fire      = 1'b1;
            acc_idx   = addr[IDX_W+1:2];
            acc_wdata = write_data;
            acc_write = MemWrite;
          end
        end else if (request) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, countdown, capture and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
    end
  end

  // Stall is combinational in IDLE so the datapath freezes in the request cycle.
  always_comb begin
    stall = ((state_q == IDLE) && legal) || (state_q == BUSY);
  end

  // A reset arriving on the access edge drops the pending write.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (fire & acc_write & ~rst),
    .re   (fire & ~acc_write),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .rdata(read_data)
  );

  assign err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder at LATENCY 2 and 1.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        st [2];
  logic        er [2];

  int          total_checks;
  int          bad_checks;
  int          lat [2];
  logic [31:0] model_mem [2][256];
  logic [31:0] exp_rd [2];

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (mr[0]),
    .MemWrite  (mw[0]),
    .addr      (ad[0]),
    .write_data(wd[0]),
    .read_data (rd[0]),
    .stall     (st[0]),
    .err       (er[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (mr[1]),
    .MemWrite  (mw[1]),
    .addr      (ad[1]),
    .write_data(wd[1]),
    .read_data (rd[1]),
    .stall     (st[1]),
    .err       (er[1])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic driveIdle(input int k);
    mr[k] = 1'b0;
    mw[k] = 1'b0;
    ad[k] = '0;
    wd[k] = '0;
  endtask

  task automatic driveNoise(input int k, input logic [31:0] a);
    mr[k] = 1'($urandom_range(0, 1));
    mw[k] = 1'($urandom_range(0, 1));
    ad[k] = a;
    wd[k] = $urandom;
  endtask

  // One complete request on DUT k; expectations come from the timing rules:
  // legal -> stall for lat cycles then DONE with data; illegal -> err one cycle later.
  task automatic applyStimulus(input int k, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] noise_addr);
    logic legal;
    int   widx;
    legal = (r ^ w) && (a[1:0] == 2'b00) && (a[31:2] < 30'd256);
    @(posedge clk); #1;
    mr[k] = r; mw[k] = w; ad[k] = a; wd[k] = d;
    @(negedge clk);
    checkOutput($sformatf("stall_req%0d", k), 32'(st[k]), 32'(legal));
    checkOutput($sformatf("err_req%0d", k), 32'(er[k]), 32'd0);
    if (legal) begin
      widx = int'(a[9:2]);
      for (int i = 1; i < lat[k]; i++) begin
        @(posedge clk); #1;
        driveNoise(k, noise_addr);
        @(negedge clk);
        checkOutput($sformatf("stall_busy%0d", k), 32'(st[k]), 32'd1);
        checkOutput($sformatf("err_busy%0d", k), 32'(er[k]), 32'd0);
      end
      if (w) model_mem[k][widx] = d;
      else   exp_rd[k] = model_mem[k][widx];
      @(posedge clk); #1;
      driveNoise(k, noise_addr);
      @(negedge clk);
      checkOutput($sformatf("stall_done%0d", k), 32'(st[k]), 32'd0);
      checkOutput($sformatf("rdata_done%0d", k), rd[k], exp_rd[k]);
      checkOutput($sformatf("err_done%0d", k), 32'(er[k]), 32'd0);
    end else begin
      @(posedge clk); #1;
      driveIdle(k);
      @(negedge clk);
      checkOutput($sformatf("err_pulse%0d", k), 32'(er[k]), 32'd1);
      checkOutput($sformatf("stall_err%0d", k), 32'(st[k]), 32'd0);
      checkOutput($sformatf("rdata_err%0d", k), rd[k], exp_rd[k]);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput($sformatf("err_clear%0d", k), 32'(er[k]), 32'd0);
    end
    @(posedge clk); #1;
    driveIdle(k);
  endtask

  initial begin
    logic        r, w;
    logic [31:0] a;
    int          kind;

    total_checks = 0;
    bad_checks   = 0;
    lat[0] = 2;
    lat[1] = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) driveIdle(k);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_stall%0d", k), 32'(st[k]), 32'd0);
      checkOutput($sformatf("rst_err%0d", k), 32'(er[k]), 32'd0);
      checkOutput($sformatf("rst_rdata%0d", k), rd[k], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Give words 0..15 known contents in both RAMs.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        applyStimulus(k, 1'b0, 1'b1, 32'(i * 4), $urandom, $urandom);

    // Store then load at 0x10.
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, $urandom);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, $urandom);

    // Single-cycle latency store/load of word 0.
    applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'h0000000F, $urandom);
    applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, $urandom);

    // Illegal requests: misaligned, both strobes, out of range.
    applyStimulus(0, 1'b1, 1'b0, 32'h06, 32'h0, $urandom);
    applyStimulus(0, 1'b1, 1'b1, 32'h0, 32'h55555555, $urandom);
    applyStimulus(0, 1'b0, 1'b1, 32'h400, 32'hAAAAAAAA, $urandom);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, $urandom);

    // Inputs moved to 0x20 during the access must not redirect it.
    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 32'h20);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h10);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h20);

    // Reset in the middle of a store drops the write.
    @(posedge clk); #1;
    mw[0] = 1'b1; ad[0] = 32'h08; wd[0] = 32'h12345678;
    @(negedge clk);
    checkOutput("rstbusy_stall_req", 32'(st[0]), 32'd1);
    @(posedge clk); #1;
    driveIdle(0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstbusy_stall_busy", 32'(st[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    checkOutput("rstbusy_stall", 32'(st[0]), 32'd0);
    checkOutput("rstbusy_rdata0", rd[0], 32'd0);
    checkOutput("rstbusy_rdata1", rd[1], 32'd0);
    checkOutput("rstbusy_err", 32'(er[0]), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h08, 32'h0, $urandom);

    // Random mix of legal accesses to words 0..15 and illegal requests.
    for (int n = 0; n < 120; n++) begin
      for (int k = 0; k < 2; k++) begin
        kind = int'($urandom_range(0, 9));
        r = 1'($urandom_range(0, 1));
        w = ~r;
        a = 32'($urandom_range(0, 15)) << 2;
        if (kind == 7) a = a | 32'($urandom_range(1, 3));
        if (kind == 8) begin r = 1'b1; w = 1'b1; end
        if (kind == 9) a = a | (32'($urandom_range(1, 1023)) << 10);
        applyStimulus(k, r, w, a, $urandom, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the single-cycle datapath's load/store interface. It samples MemRead/MemWrite, the ALU-result address and the store data, and services the access from an internal word-addressed RAM after a configurable latency. While the access is outstanding it holds the datapath with a stall. It then returns load data on read_data, which feeds the datapath's read_data_mem input.

## Interface
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of two, 16..4096.
- LATENCY, 2: total stall cycles per legal access; legal range 1..7.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- MemRead  input  1  load request from the datapath.
- MemWrite  input  1  store request from the datapath.
- addr  input  32  byte address (datapath alu_result_out).
- write_data  input  32  store data (datapath write_data_mem).
- read_data  output  32  load result; registered; reset 0.
- stall  output  1  hold the PC and instruction while high; reset 0.
- err  output  1  one-cycle pulse for an illegal request; registered; reset 0.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. The reset state is IDLE.
- IDLE:
  - A request is MemRead or MemWrite high.
  - A request is legal when all of these hold: exactly one of MemRead/MemWrite is high, addr[1:0]==0, and addr[31:2] < DEPTH_WORDS.
  - On a legal request, capture addr, write_data and the operation. Load the counter with LATENCY-1.
  - Next state is BUSY if LATENCY>1, otherwise DONE.
  - An illegal request causes no access and no stall. err pulses in the next cycle and the state stays IDLE.
- BUSY: the counter decrements each cycle. At count==1 the next state is DONE. Input changes are ignored.
- DONE:
  - For a read, read_data is updated on entry with mem[captured addr[31:2]].
  - For a write, mem[captured addr[31:2]] is written on entry. read_data is unchanged.
  - Any requests present in DONE are ignored.
  - Next state is IDLE.
- read_data holds its last load value until the next load completes.
- stall = (IDLE && legal request) || BUSY. stall is low in DONE. stall is a combinational function of the inputs in IDLE, so the datapath sees it in the request cycle.
- Reset in any state:
  - State goes to IDLE; stall, err and read_data clear.
  - A pending write is dropped.
  - RAM contents are retained (not cleared).

## Timing
- A legal request in cycle T holds stall high for cycles T..T+LATENCY-1. DONE occurs in cycle T+LATENCY with stall low and read_data valid.
- A back-to-back request from the next instruction is sampled no earlier than T+LATENCY+1. Minimum access period is LATENCY+1 cycles.
- Store data is visible to a load issued at T+LATENCY+1 or later.
- err is high in cycle T+1 only for an illegal request in cycle T.
- With LATENCY=1, stall is high in cycle T only, and DONE is at T+1.

## Structure
- Shared package dmem_pkg holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the LATENCY range constants;
  - the word-index width function clog2(DEPTH_WORDS).
- Sub-module dmem_array: single-port synchronous RAM with one write and one read port, addressed by word index, DEPTH_WORDS deep. The responder instantiates one.
- FSM, counter and capture registers live in data_mem_responder.

## Test plan
- Store then load, LATENCY=2:
  - MemWrite, addr=0x10, write_data=0xDEADBEEF in cycle T -> stall high at T and T+1, low at T+2.
  - MemRead, addr=0x10 at T+3 -> read_data=0xDEADBEEF at T+5, stall high T+3..T+4.
- LATENCY=1 load from word 0 after storing 0x0000000F -> stall high one cycle; read_data=0x0000000F the next cycle.
- Misaligned load, addr=0x06 -> stall stays 0; err=1 for exactly one cycle after the request; read_data unchanged.
- Both MemRead and MemWrite high, and a separate out-of-range addr=0x400 with DEPTH_WORDS=256:
  - each -> err pulse, no stall;
  - a subsequent load of 0x400's alias word 0 returns its prior value (no write occurred).
- Request inputs toggled during BUSY (addr changed to 0x20) -> the access still completes on the captured addr 0x10.
- rst asserted in BUSY of a store of 0x12345678 to 0x08:
  - next cycle: state IDLE, stall=0, read_data=0;
  - a later load of 0x08 returns the old contents, not 0x12345678.
